// File: rtl/conv2d_mac_serial.sv
// conv2d_mac_serial
// Serial multiply-accumulate stage for one 5x5 window. On an accepted start
// the window pixels and coefficients are captured. The 25 products are then
// summed through a single multiplier, one tap per enabled cycle. The sum is
// rounded half-up, arithmetically shifted right by OutShift and narrowed to
// the pixel width. The result is presented with a one-cycle d_valid pulse.
//
// Build option:
//   CONV_SATURATE_EN  defined   -> result is clamped to the signed pixel range
//                     undefined -> result wraps (low DataBitWidth bits kept)
module conv2d_mac_serial #(
    parameter int DataBitWidth  = 12,
    parameter int CoeffBitWidth = 8,
    parameter int FilterSize    = 5,
    parameter int OutShift      = 7
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             en,
    input  logic                                             start,
    input  logic [FilterSize*FilterSize*DataBitWidth-1:0]    win_data,
    input  logic [FilterSize*FilterSize*CoeffBitWidth-1:0]   f_coeff,
    output logic                                             busy,
    output logic [DataBitWidth-1:0]                          d_out,
    output logic                                             d_valid
);

    localparam int N  = FilterSize * FilterSize;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = DataBitWidth + CoeffBitWidth;
    localparam int AW = PW + $clog2(N);

    localparam logic [IW-1:0] LastIdx = IW'(N - 1);

    // Half of one output LSB, added before the shift for round-half-up.
    localparam int                RoundShift = (OutShift > 0) ? OutShift - 1 : 0;
    localparam logic signed [AW:0] RoundBias  = (OutShift > 0) ? (AW+1)'(1) << RoundShift : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DataBitWidth-1:0]  data_q  [N];
    logic signed [CoeffBitWidth-1:0] coeff_q [N];

    logic [IW-1:0]          idx;
    logic signed [AW-1:0]   acc;
    logic signed [PW-1:0]   prod;
    logic signed [AW:0]     rnd_sum;
    logic [DataBitWidth-1:0] res;
    logic                   accept;

    // A new window is taken only from the idle state on an enabled cycle.
    assign accept = en && start && (state == S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; en low holds the current state.
    always_comb begin
        // NOTE: default assignment first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)                  state_nxt = S_RUN;
            S_RUN:   if (en && (idx == LastIdx))  state_nxt = S_OUT;
            S_OUT:   if (en)                      state_nxt = S_IDLE;
            default:                              state_nxt = S_IDLE;
        endcase
    end

    // Output decode: busy covers RUN and OUT.
    always_comb begin
        busy = (state != S_IDLE);
    end

    // Operand capture on accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        // NOTE: operand registers have no reset; they are always rewritten on accept before being read.
        if (accept) begin
            for (int k = 0; k < N; k++) begin
                data_q[k]  <= win_data[k*DataBitWidth +: DataBitWidth];
                coeff_q[k] <= f_coeff[k*CoeffBitWidth +: CoeffBitWidth];
            end
        end
    end

    // Single shared multiplier on the current tap.
    assign prod = PW'(data_q[idx]) * PW'(coeff_q[idx]);

    // Rounding bias added at one extra bit so the add cannot overflow.
    assign rnd_sum = $signed({acc[AW-1], acc}) + RoundBias;

`ifdef CONV_SATURATE_EN
    localparam logic signed [AW:0] MaxOut = (AW+1)'((1 << (DataBitWidth - 1)) - 1);
    localparam logic signed [AW:0] MinOut = ~MaxOut;

    logic signed [AW:0] shifted;

    assign shifted = rnd_sum >>> OutShift;

    // Clamp the shifted sum into the signed pixel range.
    always_comb begin
        if (shifted > MaxOut) begin
            res = {1'b0, {(DataBitWidth-1){1'b1}}};
        end else if (shifted < MinOut) begin
            res = {1'b1, {(DataBitWidth-1){1'b0}}};
        end else begin
            res = shifted[DataBitWidth-1:0];
        end
    end
`else
    // Two's-complement wrap: keep the low pixel-width bits of the shifted sum.
    assign res = DataBitWidth'(rnd_sum >>> OutShift);
`endif

    // Accumulator, tap counter and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            idx     <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
        end else begin
            d_valid <= 1'b0;
            if (en) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            acc <= '0;
                            idx <= '0;
                        end
                    end
                    S_RUN: begin
                        acc <= acc + AW'(prod);
                        idx <= (idx == LastIdx) ? '0 : idx + 1'b1;
                    end
                    S_OUT: begin
                        d_out   <= res;
                        d_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv2d_mac_serial.sv
// Scoreboard bench for conv2d_mac_serial. Two instances share the stimulus:
// dut0 with OutShift=0 and dut7 with OutShift=7. Each accepted window pushes
// its expected pixel and due cycle into a queue per instance. A negedge
// monitor pops and compares whenever d_valid is seen.
module tb_conv2d_mac_serial;

    localparam int DW = 12;
    localparam int CW = 8;
    localparam int N  = 25;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic                  start;
    logic [N*DW-1:0]       win_data;
    logic [N*CW-1:0]       f_coeff;
    logic                  busy0, busy7;
    logic signed [DW-1:0]  d_out0, d_out7;
    logic                  d_valid0, d_valid7;

    typedef struct {
        int expv;
        int due;
    } exp_t;

    exp_t q0[$];
    exp_t q7[$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int wd[N];
    int wc[N];
    bit prev0 = 1'b0;
    bit prev7 = 1'b0;

    conv2d_mac_serial #(
        .DataBitWidth (DW),
        .CoeffBitWidth(CW),
        .FilterSize   (5),
        .OutShift     (0)
    ) dut0 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .win_data(win_data),
        .f_coeff (f_coeff),
        .busy    (busy0),
        .d_out   (d_out0),
        .d_valid (d_valid0)
    );

    conv2d_mac_serial #(
        .DataBitWidth (DW),
        .CoeffBitWidth(CW),
        .FilterSize   (5),
        .OutShift     (7)
    ) dut7 (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .win_data(win_data),
        .f_coeff (f_coeff),
        .busy    (busy7),
        .d_out   (d_out7),
        .d_valid (d_valid7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compare every d_valid against the head of the matching queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (d_valid0) begin
            check("d_valid0_width", int'(prev0), 0);
            if (q0.size() == 0) begin
                check("d_valid0_unexpected", int'(d_valid0), 0);
            end else begin
                e = q0.pop_front();
                check("d_out0", int'(d_out0), e.expv);
                check("latency0", cyc, e.due);
                check("busy0_at_valid", int'(busy0), 0);
            end
        end
        if (d_valid7) begin
            check("d_valid7_width", int'(prev7), 0);
            if (q7.size() == 0) begin
                check("d_valid7_unexpected", int'(d_valid7), 0);
            end else begin
                e = q7.pop_front();
                check("d_out7", int'(d_out7), e.expv);
                check("latency7", cyc, e.due);
            end
        end
        prev0 = d_valid0;
        prev7 = d_valid7;
    end

    // Reference convolution with round-half-up, shift and output rule.
    function automatic int ref_conv(input int shift);
        longint s = 0;
        for (int k = 0; k < N; k++) s += longint'(wd[k]) * longint'(wc[k]);
        if (shift > 0) s += longint'(1) << (shift - 1);
        s = s >>> shift;
`ifdef CONV_SATURATE_EN
        if (s > 2047)  s = 2047;
        if (s < -2048) s = -2048;
`else
        s = s & 64'hFFF;
        if (s >= 2048) s -= 4096;
`endif
        return int'(s);
    endfunction

    task automatic fill(input int d, input int c);
        for (int k = 0; k < N; k++) begin
            wd[k] = d;
            wc[k] = c;
        end
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            win_data[k*DW +: DW] = DW'(wd[k]);
            f_coeff[k*CW +: CW]  = CW'(wc[k]);
        end
    endtask

    task automatic push_exp(input int e0, input int e7, input int due);
        exp_t e;
        e.expv = e0;
        e.due  = due;
        q0.push_back(e);
        e.expv = e7;
        q7.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy0 || busy7) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", int'(busy0 | busy7), 0);
    endtask

    // Present the current window, pulse start for one edge; returns #1 after accept.
    task automatic issue(input int e0, input int e7, input int stall, input bit want);
        wait_idle();
        @(negedge clk);
        pack();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", int'(busy0), 1);
        if (want) push_exp(e0, e7, cyc + 26 + stall);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q7.size() > 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("pending0", q0.size(), 0);
        check("pending7", q7.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        start    = 1'b0;
        win_data = '0;
        f_coeff  = '0;
        fill(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy0), 0);
        check("reset_d_out", int'(d_out0), 0);
        check("reset_d_valid", int'(d_valid0), 0);
        rst = 1'b0;

        // All ones: sum 25; busy spans 26 cycles.
        fill(1, 1);
        issue(25, 0, 0, 1'b1);
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("busy_in_out_state", int'(busy0), 1);
        @(negedge clk);
        check("busy_low_at_valid", int'(busy0), 0);
        drain();

        // Single tap 3*65 = 195: 195>>7 rounds to 2, -195 rounds to -2.
        fill(0, 0);
        wd[0] = 3;
        wc[0] = 65;
        issue(195, 2, 0, 1'b1);
        drain();
        wd[0] = -3;
        issue(-195, -2, 0, 1'b1);
        drain();

        // Full-scale sums: 6499225 and -6502400.
        fill(2047, 127);
`ifdef CONV_SATURATE_EN
        issue(2047, 2047, 0, 1'b1);
`else
        issue(-1127, 1623, 0, 1'b1);
`endif
        drain();
        fill(-2048, 127);
`ifdef CONV_SATURATE_EN
        issue(-2048, -2048, 0, 1'b1);
`else
        issue(-2048, -1648, 0, 1'b1);
`endif
        drain();

        // Stall 10 cycles at idx=12 with start toggling; data k, coeff 1 -> 300.
        for (int k = 0; k < N; k++) begin
            wd[k] = k;
            wc[k] = 1;
        end
        issue(300, 2, 10, 1'b1);
        repeat (12) @(posedge clk);
        @(negedge clk);
        en    = 1'b0;
        start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("busy_in_stall", int'(busy0), 1);
        en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Abort at idx=20: no result, outputs back to reset values.
        fill(5, 1);
        issue(0, 0, 0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", int'(busy0), 0);
        check("abort_d_out0", int'(d_out0), 0);
        check("abort_d_out7", int'(d_out7), 0);
        check("abort_d_valid", int'(d_valid0), 0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        fill(7, -3);
        issue(-525, -4, 0, 1'b1);
        drain();

        // Back-to-back with start held high; window changes during RUN.
        wait_idle();
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            wd[k] = ((k * 97) % 4096) - 2048;
            wc[k] = ((k * 13) % 256) - 128;
        end
        pack();
        start = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            push_exp(ref_conv(0), ref_conv(7), cyc + 26);
            if (s < 2) begin
                for (int k = 0; k < N; k++) begin
                    wd[k] = ((k * 97 + (s + 1) * 311) % 4096) - 2048;
                    wc[k] = ((k * 13 + (s + 1) * 29) % 256) - 128;
                end
                pack();
                repeat (26) @(posedge clk);
            end else begin
                start = 1'b0;
            end
        end
        drain();
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
